// File: rtl/wb_arb.sv
// Round-robin writeback arbiter: accepts one producer result per cycle over
// valid/ready and drives a single registered register-file write port.
module wb_arb #(
  parameter int REGBITS = 5,
  parameter int LOGSIZE = 64,
  parameter int NCH     = 2,
  parameter int CNTBITS = 32,
  localparam int SRCBITS = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_stall,
  input  logic [NCH-1:0]           in_valid,
  output logic [NCH-1:0]           in_ready,
  input  logic [NCH*REGBITS-1:0]   in_rd,
  input  logic [NCH*LOGSIZE-1:0]   in_data,
  output logic                     wr_en,
  output logic [REGBITS-1:0]       wr_addr,
  output logic [LOGSIZE-1:0]       wr_data,
  output logic [SRCBITS-1:0]       wr_src,
  output logic [CNTBITS-1:0]       retire_cnt
);

  // Handshake: channel i transfers on a posedge where in_valid[i] && in_ready[i].
  // in_ready is a pure function of in_valid, rr_ptr, wb_stall and rst, so a
  // producer may hold valid/data stable until it sees ready.

  logic [SRCBITS-1:0] rr_ptr;
  logic [SRCBITS-1:0] gnt_idx;
  logic               gnt_any;
  logic [NCH-1:0]     gnt;
  logic [SRCBITS:0]   scan;
  logic [REGBITS-1:0] rd_g;
  logic [LOGSIZE-1:0] data_g;
  logic [SRCBITS-1:0] ptr_next;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    scan    = '0;
    if (!rst && !wb_stall) begin
      for (int k = 0; k < NCH; k++) begin
        // Circular search starting at rr_ptr, wrapping at NCH.
        scan = {1'b0, rr_ptr} + (SRCBITS+1)'(k);
        if (scan >= (SRCBITS+1)'(NCH)) scan = scan - (SRCBITS+1)'(NCH);
        if (!gnt_any && in_valid[scan[SRCBITS-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = scan[SRCBITS-1:0];
        end
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign in_ready = gnt;

  always_comb begin
    rd_g   = '0;
    data_g = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_idx == SRCBITS'(i)) begin
        rd_g   = in_rd[i*REGBITS +: REGBITS];
        data_g = in_data[i*LOGSIZE +: LOGSIZE];
      end
    end
  end

  always_comb begin
    if (gnt_idx == SRCBITS'(NCH-1)) ptr_next = '0;
    else                            ptr_next = gnt_idx + SRCBITS'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_src     <= '0;
      retire_cnt <= '0;
      rr_ptr     <= '0;
    end else begin
      // x0 writes retire and update the port fields, but never assert wr_en.
      wr_en <= gnt_any && (rd_g != '0);
      if (gnt_any) begin
        wr_addr    <= rd_g;
        wr_data    <= data_g;
        wr_src     <= gnt_idx;
        retire_cnt <= retire_cnt + CNTBITS'(1);
        rr_ptr     <= ptr_next;
      end
    end
  end

endmodule
